hermes_switch_control: RTL and testbench

Routing and arbitration controller for one Hermes router in the manycore mesh. It watches the five input buffers (EAST, WEST, NORTH, SOUTH, LOCAL) for packet headers and computes the XY route against the router's own address. It grants free output ports round-robin among the requesting inputs and holds each input→output connection until the input buffer reports end of packet. Its outputs drive the router crossbar selects and the buffers' header-acknowledge strobes.

---
 rtl/hermes_switch_control.sv | 146 ++++++++++++++
 tb/tb_hermes_switch_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hermes_switch_control.sv
// Hermes router switch control: XY routing of buffered headers, round-robin
// output-port arbitration, and connection hold/release on end of packet.
module hermes_switch_control #(
    parameter int          FLIT_WIDTH = 32,
    parameter logic [31:0] ADDRESS    = 32'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4:0]              h_i,
    input  logic [5*FLIT_WIDTH-1:0] header_i,
    input  logic [4:0]              sender_i,
    output logic [4:0]              ack_h_o,
    output logic [4:0]              free_o,
    output logic [14:0]             mux_in_o,
    output logic [14:0]             mux_out_o
);

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    localparam logic [7:0] LOC_X = ADDRESS[15:8];
    localparam logic [7:0] LOC_Y = ADDRESS[7:0];

    typedef enum logic [2:0] {IDLE, SELECT, ROUTE, GRANT, ACK} state_t;

    state_t               state_q, state_d;
    logic [4:0]           conn_q, conn_d;
    logic [4:0]           free_q, free_d;
    logic [4:0][2:0]      mux_in_q, mux_in_d;
    logic [4:0][2:0]      mux_out_q, mux_out_d;
    logic [2:0]           last_q, sel_q, dir_q;
    logic [2:0]           pick, cand;
    logic                 found;
    logic [4:0]           elig;
    logic                 grant_ok;
    logic [FLIT_WIDTH-1:0] hdr_sel;
    logic                 unused_hdr;

    function automatic logic [2:0] xy_route(input logic [15:0] tgt);
        if (tgt[15:8] > LOC_X)      return EAST;
        else if (tgt[15:8] < LOC_X) return WEST;
        else if (tgt[7:0] > LOC_Y)  return NORTH;
        else if (tgt[7:0] < LOC_Y)  return SOUTH;
        else                        return LOCAL;
    endfunction

    assign elig     = h_i & ~conn_q;
    assign grant_ok = (state_q == GRANT) && h_i[sel_q] && free_q[dir_q];

    // Round-robin scan starting one past the last selected input.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int i = 0; i < 5; i++) begin
            cand = (cand >= 3'd4) ? 3'd0 : cand + 3'd1;
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        hdr_sel = '0;
        for (int k = 0; k < 5; k++) begin
            if (sel_q == 3'(k)) hdr_sel = header_i[k*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    // Only the target address field of the flit takes part in routing.
    assign unused_hdr = ^hdr_sel[FLIT_WIDTH-1:16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|elig) state_d = SELECT;
            SELECT:  state_d = found ? ROUTE : IDLE;
            ROUTE:   state_d = GRANT;
            GRANT:   state_d = grant_ok ? ACK : IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_h_o = '0;
        if (state_q == ACK) ack_h_o[sel_q] = 1'b1;
    end

    // Release and grant never touch the same port: a grant needs the registered
    // port free, and a releasing input is already connected.
    always_comb begin
        conn_d    = conn_q;
        free_d    = free_q;
        mux_in_d  = mux_in_q;
        mux_out_d = mux_out_q;
        for (int k = 0; k < 5; k++) begin
            if (conn_q[k] && !sender_i[k]) begin
                conn_d[k]              = 1'b0;
                free_d[mux_out_q[k]]   = 1'b1;
            end
        end
        if (grant_ok) begin
            free_d[dir_q]    = 1'b0;
            conn_d[sel_q]    = 1'b1;
            mux_in_d[dir_q]  = sel_q;
            mux_out_d[sel_q] = dir_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conn_q    <= '0;
            free_q    <= '1;
            mux_in_q  <= '0;
            mux_out_q <= '0;
            last_q    <= LOCAL;
            sel_q     <= EAST;
            dir_q     <= EAST;
        end else begin
            conn_q    <= conn_d;
            free_q    <= free_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
            if (state_q == SELECT && found) begin
                sel_q  <= pick;
                last_q <= pick;
            end
            if (state_q == ROUTE) dir_q <= xy_route(hdr_sel[15:0]);
        end
    end

    assign free_o    = free_q;
    assign mux_in_o  = mux_in_q;
    assign mux_out_o = mux_out_q;

endmodule

// File: tb/tb_hermes_switch_control.sv
// Directed bench for hermes_switch_control: table of single-header routes plus
// hand-written multi-header, collision, withdrawal and reset sequences.
module tb_hermes_switch_control;

    logic         clock;
    logic         reset;
    logic [4:0]   h_i;
    logic [159:0] header_i;
    logic [4:0]   sender_i;
    logic [4:0]   ack_h_o;
    logic [4:0]   free_o;
    logic [14:0]  mux_in_o;
    logic [14:0]  mux_out_o;

    int checks   = 0;
    int failures = 0;

    hermes_switch_control #(.FLIT_WIDTH(32), .ADDRESS(32'h0101)) dut (
        .clock    (clock),
        .reset    (reset),
        .h_i      (h_i),
        .header_i (header_i),
        .sender_i (sender_i),
        .ack_h_o  (ack_h_o),
        .free_o   (free_o),
        .mux_in_o (mux_in_o),
        .mux_out_o(mux_out_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          port;
        logic [15:0] hdr;
        int          dir;
    } vec_t;

    vec_t vecs[12];
    int   ack_cyc[5];
    int   pulses;
    int   n;
    logic got;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_hdr(input int p, input logic [15:0] hdr);
        header_i[p*32 +: 32] = {16'hA5A5, hdr};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Local address X=1, Y=1.
        vecs[0]  = '{1, 16'h0301, 0};
        vecs[1]  = '{0, 16'h0001, 1};
        vecs[2]  = '{2, 16'h0100, 3};
        vecs[3]  = '{3, 16'h0102, 2};
        vecs[4]  = '{4, 16'h0101, 4};
        vecs[5]  = '{0, 16'h0101, 4};
        vecs[6]  = '{4, 16'hFF00, 0};
        vecs[7]  = '{1, 16'h00FF, 1};
        vecs[8]  = '{2, 16'h01FF, 2};
        vecs[9]  = '{3, 16'h0100, 3};
        vecs[10] = '{2, 16'h0180, 2};
        vecs[11] = '{4, 16'h8001, 0};

        reset    = 1'b0;
        h_i      = '0;
        sender_i = '0;
        header_i = '0;
        #2 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_ack", 32'(ack_h_o), 32'h0);
        check("rst_free", 32'(free_o), 32'h1f);
        check("rst_mux_in", 32'(mux_in_o), 32'h0);
        check("rst_mux_out", 32'(mux_out_o), 32'h0);

        // Header withdrawn while the FSM is in ROUTE.
        set_hdr(1, 16'h0301);
        sender_i[1] = 1'b1;
        h_i[1]      = 1'b1;
        pulses      = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (cyc == 2) h_i[1] = 1'b0;
            if (ack_h_o != 5'b0) pulses++;
        end
        check("withdraw_acks", 32'(pulses), 32'd0);
        check("withdraw_free", 32'(free_o), 32'h1f);
        sender_i[1] = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set_hdr(vecs[i].port, vecs[i].hdr);
            sender_i[vecs[i].port] = 1'b1;
            h_i[vecs[i].port]      = 1'b1;
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                tick();
                n++;
                got = ack_h_o[vecs[i].port];
            end
            check($sformatf("v%0d_latency", i), 32'(n), 32'd4);
            check($sformatf("v%0d_free", i), 32'(free_o), 32'(5'h1f & ~(5'b1 << vecs[i].dir)));
            check($sformatf("v%0d_mux_in", i), 32'(mux_in_o[3*vecs[i].dir +: 3]), 32'(vecs[i].port));
            check($sformatf("v%0d_mux_out", i), 32'(mux_out_o[3*vecs[i].port +: 3]), 32'(vecs[i].dir));
            h_i[vecs[i].port] = 1'b0;
            tick();
            check($sformatf("v%0d_ack_drop", i), 32'(ack_h_o), 32'h0);
            sender_i[vecs[i].port] = 1'b0;
            tick();
            check($sformatf("v%0d_release", i), 32'(free_o), 32'h1f);
        end

        // Three simultaneous headers, pointer at LOCAL: NORTH, SOUTH, LOCAL order.
        set_hdr(2, 16'h0100);
        set_hdr(3, 16'h0102);
        set_hdr(4, 16'h0101);
        sender_i = 5'b11100;
        h_i      = 5'b11100;
        for (int k = 0; k < 5; k++) ack_cyc[k] = -1;
        pulses = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            if (ack_h_o != 5'b0) pulses++;
            for (int k = 0; k < 5; k++) begin
                if (ack_h_o[k]) begin
                    if (ack_cyc[k] < 0) ack_cyc[k] = cyc;
                    h_i[k] = 1'b0;
                end
            end
        end
        check("multi_ack_north", 32'(ack_cyc[2]), 32'd4);
        check("multi_ack_south", 32'(ack_cyc[3]), 32'd9);
        check("multi_ack_local", 32'(ack_cyc[4]), 32'd14);
        check("multi_pulses", 32'(pulses), 32'd3);
        check("multi_free", 32'(free_o), 32'b00011);
        check("multi_mux_in_s", 32'(mux_in_o[9 +: 3]), 32'd2);
        check("multi_mux_in_n", 32'(mux_in_o[6 +: 3]), 32'd3);
        check("multi_mux_out_l", 32'(mux_out_o[12 +: 3]), 32'd4);

        // EAST granted while LOCAL releases in the same cycle; then reset in ACK.
        set_hdr(0, 16'h0201);
        sender_i[0] = 1'b1;
        h_i[0]      = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 3) begin
                check("collide_pre_free", 32'(free_o), 32'b00011);
                sender_i[4] = 1'b0;
            end
        end
        check("collide_free", 32'(free_o), 32'b10010);
        check("collide_ack", 32'(ack_h_o), 32'b00001);
        check("collide_mux_out", 32'(mux_out_o[0 +: 3]), 32'd0);
        check("collide_mux_in", 32'(mux_in_o[0 +: 3]), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_ack", 32'(ack_h_o), 32'h0);
        check("arst_free", 32'(free_o), 32'h1f);
        check("arst_mux_in", 32'(mux_in_o), 32'h0);
        check("arst_mux_out", 32'(mux_out_o), 32'h0);
        h_i      = '0;
        sender_i = '0;
        tick();
        reset = 1'b0;
        tick();

        // EAST, WEST, NORTH all target LOCAL; releases at cycles 14 and 26.
        set_hdr(0, 16'h0101);
        set_hdr(1, 16'h0101);
        set_hdr(2, 16'h0101);
        sender_i = 5'b00111;
        h_i      = 5'b00111;
        for (int k = 0; k < 5; k++) ack_cyc[k] = -1;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            tick();
            for (int k = 0; k < 5; k++) begin
                if (ack_h_o[k]) begin
                    if (ack_cyc[k] < 0) ack_cyc[k] = cyc;
                    h_i[k] = 1'b0;
                end
            end
            if (cyc == 14) sender_i[0] = 1'b0;
            if (cyc == 26) sender_i[1] = 1'b0;
        end
        check("rr_ack_east", 32'(ack_cyc[0]), 32'd4);
        check("rr_ack_west", 32'(ack_cyc[1]), 32'd17);
        check("rr_ack_north", 32'(ack_cyc[2]), 32'd30);
        check("rr_free", 32'(free_o), 32'b01111);
        check("rr_mux_in_local", 32'(mux_in_o[12 +: 3]), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
